dvi_scanout: RTL
================

DVI_SCANOUT -- requirements
Module: dvi_scanout

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameters H_FRONT/H_SYNC/H_BACK, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameters V_ACTIVE/V_FRONT/V_SYNC/V_BACK, defaults 480/10/2/33, in lines.
REQ-004 SHALL have parameter SYNC_POL, default 0, active sync level (0 = active-low).
REQ-005 SHALL have parameter UNDERFLOW_RGB, default 24'hFF00FF, colour substituted on underflow.
REQ-006 clk_dvi  in  1  pixel clock; one clock, all logic on rising edge.
REQ-007 rst_dvi  in  1  reset, synchronous, active-high.
REQ-008 framebuffer_ready  in  1  upstream FIFO holds enough pixels to start.
REQ-009 framebuffer_pull  out  1  read-enable to upstream FIFO, read latency 1.
REQ-010 framebuffer_data  in  24  RGB888_t pixel, valid with framebuffer_valid.
REQ-011 framebuffer_valid  in  1  upstream data_valid, one cycle after pull.
REQ-012 hsync, vsync, de  out  1 each  DVI timing to the encoder.
REQ-013 rgb  out  24  RGB888_t pixel to the encoder.
REQ-014 frame_start  out  1  one-cycle pulse, aligned with first de of a frame.
REQ-015 underflow  out  1  sticky flag; clear_underflow  in  1  clears it and the counter.
REQ-016 underflow_count  out  16  saturating count of starved active pixels.

Function
REQ-017 h_cnt SHALL count 0..H_TOTAL-1 (sum of H params) every cycle, wrapping to 0; v_cnt SHALL increment on h wrap, 0..V_TOTAL-1, wrapping to 0.
REQ-018 Counters SHALL free-run from reset regardless of state, so sync is always present.
REQ-019 Stage-0 active = h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; hsync asserted for H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC; vsync likewise on v_cnt.
REQ-020 State machine SHALL have states WAIT_READY and RUNNING.
REQ-021 WAIT_READY -> RUNNING only at h_cnt==0 and v_cnt==0 with framebuffer_ready high; never mid-frame.
REQ-022 RUNNING -> WAIT_READY in the cycle after framebuffer_ready is sampled low; pull deasserts that cycle.
REQ-023 framebuffer_pull SHALL be combinational = RUNNING and stage-0 active.
REQ-024 hsync, vsync, de SHALL be stage-0 values delayed exactly 2 registers; de asserted only while RUNNING.
REQ-025 rgb SHALL register framebuffer_data when framebuffer_valid, else UNDERFLOW_RGB during de, else 0; aligned with de.
REQ-026 Underflow: stage-1 pixel expected (pull one cycle earlier) and framebuffer_valid low -> underflow set, count +1, saturating at 16'hFFFF.
REQ-027 framebuffer_valid without prior pull SHALL be ignored and the data discarded.
REQ-028 clear_underflow coincident with a new underflow: clear wins, flag and count read 0.
REQ-029 frame_start SHALL pulse with the de of pixel (0,0) of each RUNNING frame.
REQ-030 Widths: counters sized by $clog2 of totals; no truncation of sums.

Reset
REQ-031 While rst_dvi high: h_cnt=v_cnt=0, state WAIT_READY, pipeline cleared.
REQ-032 Reset outputs: hsync=vsync=~SYNC_POL, de=0, rgb=0, pull=0, frame_start=0, underflow=0, underflow_count=0.
REQ-033 Reset mid-frame SHALL abort immediately; pull low in the same cycle rst_dvi is sampled.

Configuration
REQ-034 Macro DVI_SCANOUT_TESTPATTERN_EN, when defined, SHALL add input test_pattern (1 bit).
REQ-035 With macro and test_pattern high: rgb = eight equal vertical colour bars (white, yellow, cyan, green, magenta, red, blue, black) by h_cnt; pulls and underflow accounting unchanged.
REQ-036 Without macro: port absent, rgb sourced only per REQ-025.

Verification (sim params H 8/2/2/2, V 4/1/1/1, SYNC_POL 0)
REQ-037 Reset, ready low 3 frames -> hsync low 2 cycles every 14, vsync low 1 line of 7, de and pull never high.
REQ-038 Ready raised mid-frame, FIFO always valid -> first pull at next (0,0); 32 de cycles per frame, rgb equals FIFO sequence, frame_start once.
REQ-039 Valid withheld for 3 active pixels -> rgb=FF00FF on those 3, underflow=1, underflow_count=3.
REQ-040 Ready dropped at pixel (3,1) -> pull low next cycle, de low thereafter, restart only at next (0,0) with ready.
REQ-041 underflow_count preloaded near 16'hFFFF, 5 more starved pixels -> holds 16'hFFFF; clear_underflow -> 0.
REQ-042 Macro defined, test_pattern high -> pixel h_cnt 0 white, h_cnt 7 black, pull count per frame still 32.

Source files
------------

// File: rtl/dvi_scanout_if.sv
// rtl/dvi_scanout_if.sv - pixel pull interface between the upstream framebuffer FIFO and dvi_scanout
interface dvi_scanout_if;
  logic        framebuffer_ready;
  logic        framebuffer_pull;
  logic [23:0] framebuffer_data;
  logic        framebuffer_valid;

  // master is the FIFO side that supplies pixels; slave is the scanout that pulls them
  modport master (output framebuffer_ready, output framebuffer_data, output framebuffer_valid,
                  input  framebuffer_pull);
  modport slave  (input  framebuffer_ready, input  framebuffer_data, input  framebuffer_valid,
                  output framebuffer_pull);
endinterface

// File: rtl/dvi_scanout.sv
// rtl/dvi_scanout.sv - DVI raster timing and pixel scanout; optional macro DVI_SCANOUT_TESTPATTERN_EN adds colour bars
module dvi_scanout #(
  parameter int          H_ACTIVE      = 640,
  parameter int          H_FRONT       = 16,
  parameter int          H_SYNC        = 96,
  parameter int          H_BACK        = 48,
  parameter int          V_ACTIVE      = 480,
  parameter int          V_FRONT       = 10,
  parameter int          V_SYNC        = 2,
  parameter int          V_BACK        = 33,
  parameter bit          SYNC_POL      = 1'b0,
  parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
  input  logic         clk_dvi,
  input  logic         rst_dvi,
  dvi_scanout_if.slave fb,
  output logic         hsync,
  output logic         vsync,
  output logic         de,
  output logic [23:0]  rgb,
  output logic         frame_start,
  output logic         underflow,
  output logic [15:0]  underflow_count,
  input  logic         clear_underflow
`ifdef DVI_SCANOUT_TESTPATTERN_EN
  ,
  input  logic         test_pattern
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  typedef enum logic {WAIT_READY, RUNNING} state_t;

  state_t        state;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last, v_last, act0, hs0, vs0, first0, pull;
  logic          act1, hs1, vs1, first1;
  logic [23:0]   pix_next;
`ifdef DVI_SCANOUT_TESTPATTERN_EN
  logic [HW-1:0] h1;
`endif

  // Stage-0 raster decode; comparisons done at int width so porch sums never truncate
  always_comb begin
    h_last = (int'(h_cnt) == H_TOTAL - 1);
    v_last = (int'(v_cnt) == V_TOTAL - 1);
    act0   = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    hs0    = (int'(h_cnt) >= H_ACTIVE + H_FRONT) && (int'(h_cnt) < H_ACTIVE + H_FRONT + H_SYNC);
    vs0    = (int'(v_cnt) >= V_ACTIVE + V_FRONT) && (int'(v_cnt) < V_ACTIVE + V_FRONT + V_SYNC);
    first0 = (int'(h_cnt) == 0) && (int'(v_cnt) == 0);
    pull   = (state == RUNNING) && act0 && !rst_dvi;
  end

  assign fb.framebuffer_pull = pull;

  // Free-running raster counters so sync is produced even while starved
  always_ff @(posedge clk_dvi) begin
    if (rst_dvi) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Start only on the edge that enters pixel (0,0) so a frame is never joined mid-way
  always_ff @(posedge clk_dvi) begin
    if (rst_dvi) begin
      state <= WAIT_READY;
    end else begin
      case (state)
        WAIT_READY: if (h_last && v_last && fb.framebuffer_ready) state <= RUNNING;
        RUNNING:    if (!fb.framebuffer_ready) state <= WAIT_READY;
        default:    state <= WAIT_READY;
      endcase
    end
  end

  // Stage-1: timing delayed to line up with the FIFO's one-cycle read latency
  always_ff @(posedge clk_dvi) begin
    if (rst_dvi) begin
      act1   <= 1'b0;
      hs1    <= 1'b0;
      vs1    <= 1'b0;
      first1 <= 1'b0;
    end else begin
      act1   <= pull;
      hs1    <= hs0;
      vs1    <= vs0;
      first1 <= pull && first0;
    end
  end

`ifdef DVI_SCANOUT_TESTPATTERN_EN
  function automatic logic [23:0] bar_colour(input int idx);
    case (idx)
      0:       bar_colour = 24'hFFFFFF;
      1:       bar_colour = 24'hFFFF00;
      2:       bar_colour = 24'h00FFFF;
      3:       bar_colour = 24'h00FF00;
      4:       bar_colour = 24'hFF00FF;
      5:       bar_colour = 24'hFF0000;
      6:       bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction

  // Horizontal position of the stage-1 pixel, used only to pick a colour bar
  always_ff @(posedge clk_dvi) begin
    if (rst_dvi) h1 <= '0;
    else         h1 <= h_cnt;
  end
`endif

  // Pixel select: valid data only when a pull was issued; stray valids are dropped
  always_comb begin
    pix_next = 24'h000000;
    if (act1) pix_next = fb.framebuffer_valid ? fb.framebuffer_data : UNDERFLOW_RGB;
`ifdef DVI_SCANOUT_TESTPATTERN_EN
    if (act1 && test_pattern) pix_next = bar_colour((int'(h1) * 8) / H_ACTIVE);
`endif
  end

  // Stage-2 output registers towards the encoder
  always_ff @(posedge clk_dvi) begin
    if (rst_dvi) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
      rgb         <= 24'h000000;
    end else begin
      hsync       <= hs1 ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs1 ? SYNC_POL : ~SYNC_POL;
      de          <= act1;
      frame_start <= first1;
      rgb         <= pix_next;
    end
  end

  // Starvation accounting; a clear in the same cycle as a new underflow wins
  always_ff @(posedge clk_dvi) begin
    if (rst_dvi || clear_underflow) begin
      underflow       <= 1'b0;
      underflow_count <= 16'h0000;
    end else if (act1 && !fb.framebuffer_valid) begin
      underflow <= 1'b1;
      if (underflow_count != 16'hFFFF) underflow_count <= underflow_count + 16'd1;
    end
  end

endmodule
